// File: rtl/regfile_pkg.sv
// Shared constants and payload types for the register-file writeback path.
//   DEF_DATA_W / DEF_ADDR_W : default register data and address widths
//   REG_ZERO                : architectural x0, never written and never busy
//   wb_req_t                : one writeback payload {addr, data}
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i[1:0] : request per port
//   gnt_o[1:0] : one-hot grant (combinational), zero when nothing requests
// last_gnt_q remembers the most recently granted port; on a conflict the
// other port wins. It resets to 1 so port 0 wins the first conflict.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_gnt_q;
    logic last_gnt_d;

    // Grant decode and pointer update
    always_comb begin
        gnt_o      = 2'b00;
        last_gnt_d = last_gnt_q;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_gnt_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (|gnt_o) begin
            last_gnt_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
// Two writeback sources (port 0 = ALU, port 1 = load unit) share the single
// register-file write port. The winner is registered for one cycle and
// presented on AddrD/DataD/RegWEn. A busy bit per register lets the issue
// stage stall on read-after-write hazards.
//   Clk, RstN                     : clock, asynchronous active-low reset
//   Req{0,1}Valid/Addr/Data/Ready : writeback requests, Ready = grant (comb)
//   ClaimValid/ClaimAddr          : issue stage reserves a destination
//   RsA/RsB -> BusyA/BusyB        : pending-write query (comb)
//   FwdA/FwdB/FwdDataA/FwdDataB   : same-cycle bypass of the committing write
//   AddrD/DataD/RegWEn            : registered register-file write port
// Optional feature: define REGFILE_WB_BYPASS_EN to build the bypass
// comparators; otherwise the Fwd* outputs are tied to 0.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              Req0Valid,
    input  logic [ADDR_W-1:0] Req0Addr,
    input  logic [DATA_W-1:0] Req0Data,
    output logic              Req0Ready,
    input  logic              Req1Valid,
    input  logic [ADDR_W-1:0] Req1Addr,
    input  logic [DATA_W-1:0] Req1Data,
    output logic              Req1Ready,
    input  logic              ClaimValid,
    input  logic [ADDR_W-1:0] ClaimAddr,
    input  logic [ADDR_W-1:0] RsA,
    input  logic [ADDR_W-1:0] RsB,
    output logic              BusyA,
    output logic              BusyB,
    output logic              FwdA,
    output logic              FwdB,
    output logic [DATA_W-1:0] FwdDataA,
    output logic [DATA_W-1:0] FwdDataB,
    output logic [ADDR_W-1:0] AddrD,
    output logic [DATA_W-1:0] DataD,
    output logic              RegWEn
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [1:0]          gnt;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;

    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                wen_q, wen_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    rr_arb2 u_arb (
        .clk   (Clk),
        .rst_n (RstN),
        .req_i ({Req1Valid, Req0Valid}),
        .gnt_o (gnt)
    );

    assign Req0Ready = gnt[0];
    assign Req1Ready = gnt[1];

    // Winning payload
    assign win_addr = gnt[1] ? Req1Addr : Req0Addr;
    assign win_data = gnt[1] ? Req1Data : Req0Data;

    // Write-port staging: address/data load on any grant, enable only for rd != x0
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        wen_d  = 1'b0;
        if (|gnt) begin
            addr_d = win_addr;
            data_d = win_data;
            wen_d  = (win_addr != ZERO_ADDR);
        end
    end

    // Scoreboard: clear on commit first, then claim, so a same-address claim wins
    always_comb begin
        busy_d = busy_q;
        if (wen_q) begin
            busy_d[addr_q] = 1'b0;
        end
        if (ClaimValid && (ClaimAddr != ZERO_ADDR)) begin
            busy_d[ClaimAddr] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            addr_q <= '0;
            data_q <= '0;
            wen_q  <= 1'b0;
            busy_q <= '0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            wen_q  <= wen_d;
            busy_q <= busy_d;
        end
    end

    assign AddrD  = addr_q;
    assign DataD  = data_q;
    assign RegWEn = wen_q;

    assign BusyA = busy_q[RsA];
    assign BusyB = busy_q[RsB];

`ifdef REGFILE_WB_BYPASS_EN
    // Committing write matches a source operand this cycle
    assign FwdA     = wen_q && (addr_q == RsA) && (RsA != ZERO_ADDR);
    assign FwdB     = wen_q && (addr_q == RsB) && (RsB != ZERO_ADDR);
    assign FwdDataA = data_q;
    assign FwdDataB = data_q;
`else
    assign FwdA     = 1'b0;
    assign FwdB     = 1'b0;
    assign FwdDataA = '0;
    assign FwdDataB = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed stimulus, a
// behavioural model checked on every falling edge, and literal expectations.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic        Clk = 1'b0;
    logic        RstN;
    logic        Req0Valid, Req1Valid, ClaimValid;
    logic [4:0]  Req0Addr, Req1Addr, ClaimAddr, RsA, RsB;
    logic [31:0] Req0Data, Req1Data;
    logic        Req0Ready, Req1Ready, BusyA, BusyB, FwdA, FwdB, RegWEn;
    logic [31:0] FwdDataA, FwdDataB, DataD;
    logic [4:0]  AddrD;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter dut (
        .Clk(Clk), .RstN(RstN),
        .Req0Valid(Req0Valid), .Req0Addr(Req0Addr), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
        .Req1Valid(Req1Valid), .Req1Addr(Req1Addr), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
        .ClaimValid(ClaimValid), .ClaimAddr(ClaimAddr),
        .RsA(RsA), .RsB(RsB), .BusyA(BusyA), .BusyB(BusyB),
        .FwdA(FwdA), .FwdB(FwdB), .FwdDataA(FwdDataA), .FwdDataB(FwdDataB),
        .AddrD(AddrD), .DataD(DataD), .RegWEn(RegWEn)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who last won, which registers are pending,
    // and the write that will be visible on the port after the next edge.
    logic    m_last;
    bit      m_busy [32];
    logic    m_wen;
    wb_req_t m_pend;

    always @(negedge Clk) begin
        logic g0, g1, fa, fb;
        logic [31:0] fda, fdb;
        if (!RstN) begin
            m_last = 1'b1;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_wen  = 1'b0;
            m_pend = '0;
        end else begin
            g0 = Req0Valid && (!Req1Valid || m_last == 1'b1);
            g1 = Req1Valid && !g0;
`ifdef REGFILE_WB_BYPASS_EN
            fa  = m_wen && m_pend.addr == RsA && RsA != 5'd0;
            fb  = m_wen && m_pend.addr == RsB && RsB != 5'd0;
            fda = m_pend.data;
            fdb = m_pend.data;
`else
            fa  = 1'b0;
            fb  = 1'b0;
            fda = 32'd0;
            fdb = 32'd0;
`endif
            chk("m_ready0", 32'(Req0Ready), 32'(g0));
            chk("m_ready1", 32'(Req1Ready), 32'(g1));
            chk("m_busyA",  32'(BusyA),     32'(m_busy[RsA]));
            chk("m_busyB",  32'(BusyB),     32'(m_busy[RsB]));
            chk("m_wen",    32'(RegWEn),    32'(m_wen));
            chk("m_addrd",  32'(AddrD),     32'(m_pend.addr));
            chk("m_datad",  DataD,          m_pend.data);
            chk("m_fwdA",   32'(FwdA),      32'(fa));
            chk("m_fwdB",   32'(FwdB),      32'(fb));
            chk("m_fwddA",  FwdDataA,       fda);
            chk("m_fwddB",  FwdDataB,       fdb);
            // Advance to the state after the coming rising edge
            if (m_wen) m_busy[m_pend.addr] = 1'b0;
            if (ClaimValid && ClaimAddr != 5'd0) m_busy[ClaimAddr] = 1'b1;
            m_wen = 1'b0;
            if (g0 || g1) begin
                m_last      = g1;
                m_pend.addr = g1 ? Req1Addr : Req0Addr;
                m_pend.data = g1 ? Req1Data : Req0Data;
                m_wen       = (m_pend.addr != 5'd0);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        RstN = 1'b0;
        Req0Valid = 1'b0; Req0Addr = '0; Req0Data = '0;
        Req1Valid = 1'b0; Req1Addr = '0; Req1Data = '0;
        ClaimValid = 1'b0; ClaimAddr = '0; RsA = '0; RsB = '0;
        tick(); tick();
        chk("rst_wen", 32'(RegWEn), 32'd0);
        chk("rst_addr", 32'(AddrD), 32'd0);
        RstN = 1'b1;

        // Conflict straight after reset: grants alternate starting with port 0
        Req0Valid = 1'b1; Req0Addr = 5'd1; Req0Data = 32'h11;
        Req1Valid = 1'b1; Req1Addr = 5'd2; Req1Data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("conf_r0", 32'(Req0Ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("conf_r1", 32'(Req1Ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("conf_wen", 32'(RegWEn), 32'd1);
            chk("conf_addr", 32'(AddrD), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        Req0Valid = 1'b0; Req1Valid = 1'b0;

        // Single requester latency
        tick();
        Req0Valid = 1'b1; Req0Addr = 5'd5; Req0Data = 32'hDEADBEEF;
        #1 chk("single_rdy", 32'(Req0Ready), 32'd1);
        tick();
        Req0Valid = 1'b0;
        chk("single_wen", 32'(RegWEn), 32'd1);
        chk("single_addr", 32'(AddrD), 32'd5);
        chk("single_data", DataD, 32'hDEADBEEF);
        tick();
        chk("single_idle", 32'(RegWEn), 32'd0);

        // Scoreboard claim / clear, including claim-wins on the clearing edge
        ClaimValid = 1'b1; ClaimAddr = 5'd7;
        tick();
        ClaimValid = 1'b0; RsA = 5'd7;
        #1 chk("sb_set", 32'(BusyA), 32'd1);
        Req0Valid = 1'b1; Req0Addr = 5'd7; Req0Data = 32'h77;
        tick();
        Req0Valid = 1'b0; ClaimValid = 1'b1; ClaimAddr = 5'd7;
        chk("sb_commit_wen", 32'(RegWEn), 32'd1);
        chk("sb_pending", 32'(BusyA), 32'd1);
        tick();
        ClaimValid = 1'b0;
        chk("sb_claim_wins", 32'(BusyA), 32'd1);
        Req0Valid = 1'b1; Req0Data = 32'h78;
        tick();
        Req0Valid = 1'b0;
        chk("sb_still", 32'(BusyA), 32'd1);
        tick();
        chk("sb_clear", 32'(BusyA), 32'd0);

        // x0 writes and claims
        Req1Valid = 1'b1; Req1Addr = 5'd0; Req1Data = 32'h1234;
        #1 chk("x0_rdy", 32'(Req1Ready), 32'd1);
        tick();
        Req1Valid = 1'b0;
        chk("x0_wen", 32'(RegWEn), 32'd0);
        chk("x0_data", DataD, 32'h1234);
        ClaimValid = 1'b1; ClaimAddr = 5'd0; RsA = 5'd0;
        tick();
        ClaimValid = 1'b0;
        chk("x0_busy", 32'(BusyA), 32'd0);

        // Bypass
        Req0Valid = 1'b1; Req0Addr = 5'd9; Req0Data = 32'h55;
        tick();
        Req0Valid = 1'b0; RsB = 5'd9;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        chk("fwdB", 32'(FwdB), 32'd1);
        chk("fwdDataB", FwdDataB, 32'h55);
`else
        chk("fwdB", 32'(FwdB), 32'd0);
        chk("fwdDataB", FwdDataB, 32'd0);
`endif
        chk("fwd_wen", 32'(RegWEn), 32'd1);

        // Mid-stream asynchronous reset with both requesters valid
        tick();
        ClaimValid = 1'b1; ClaimAddr = 5'd3;
        tick();
        ClaimValid = 1'b0; RsA = 5'd3;
        Req0Valid = 1'b1; Req0Addr = 5'd3; Req0Data = 32'hA3;
        Req1Valid = 1'b1; Req1Addr = 5'd4; Req1Data = 32'hB4;
        tick();
        chk("pre_rst_busy", 32'(BusyA), 32'd1);
        RstN = 1'b0;
        #1;
        chk("arst_wen", 32'(RegWEn), 32'd0);
        chk("arst_addr", 32'(AddrD), 32'd0);
        chk("arst_data", DataD, 32'd0);
        chk("arst_busyA", 32'(BusyA), 32'd0);
        chk("arst_busyB", 32'(BusyB), 32'd0);
        tick(); tick();
        RstN = 1'b1;
        #1;
        chk("post_rst_r0", 32'(Req0Ready), 32'd1);
        chk("post_rst_r1", 32'(Req1Ready), 32'd0);
        tick();
        chk("post_rst_2nd", 32'(Req1Ready), 32'd1);
        tick();
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (AddrD/DataD/RegWEn) between two writeback requesters: the ALU (port 0) and the load unit (port 1).
- Arbitrates with round-robin priority and registers the winning write for one cycle before it reaches the register file.
- Keeps a 32-entry pending-write scoreboard so the issue stage can stall on rs1/rs2 read-after-write hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; the scoreboard has 2**ADDR_W entries

Ports:
Clk  in  1  clock, rising edge
RstN  in  1  asynchronous active-low reset
Req0Valid  in  1  ALU writeback request
Req0Addr  in  ADDR_W  ALU destination rd
Req0Data  in  DATA_W  ALU result
Req0Ready  out  1  ALU request accepted this cycle
Req1Valid  in  1  load writeback request
Req1Addr  in  ADDR_W  load destination rd
Req1Data  in  DATA_W  load data
Req1Ready  out  1  load request accepted this cycle
ClaimValid  in  1  issue stage reserves a destination register
ClaimAddr  in  ADDR_W  register being reserved
RsA  in  ADDR_W  rs1 query address
RsB  in  ADDR_W  rs2 query address
BusyA  out  1  rs1 has a pending write
BusyB  out  1  rs2 has a pending write
FwdA  out  1  bypass hit on rs1 (optional feature)
FwdB  out  1  bypass hit on rs2 (optional feature)
FwdDataA  out  DATA_W  bypass data for rs1
FwdDataB  out  DATA_W  bypass data for rs2
AddrD  out  ADDR_W  to register file
DataD  out  DATA_W  to register file
RegWEn  out  1  to register file

Behaviour:
- Reset (RstN low, asynchronous):
  - AddrD, DataD and RegWEn are 0.
  - Scoreboard is cleared.
  - Round-robin pointer LastGnt is 1, so port 0 wins the first conflict.
  - Writes in flight are discarded.
- Handshake: ReqXReady is combinational and means "grant to X". There is no back-pressure from the register file.
  - Only one port valid: that port is granted.
  - Both valid: the port that is not LastGnt is granted.
  - LastGnt updates on every grant.
  - At most one Ready is high per cycle.
  - Ready never asserts without the matching Valid.
- Latency: request granted in cycle N → AddrD/DataD registered at the end of N → RegWEn high during N+1 → register file writes at the end of N+1.
  - Sustained throughput is one write per cycle.
  - RegWEn is low in any cycle that follows a cycle with no grant.
- rd = 0:
  - The request is granted normally, but RegWEn stays 0. AddrD and DataD still load.
  - Claims of x0 are ignored; BusyA/BusyB are never 1 for address 0.
- Scoreboard, busy[31:0]:
  - Set on the rising edge when ClaimValid is high.
  - Cleared on the same edge the register file commits, i.e. when RegWEn is high, at bit AddrD.
  - Claim and clear of the same address on one edge: the claim wins and the bit stays 1 (a new producer exists).
  - Claim and clear of different addresses on one edge: both take effect.
  - BusyA = busy[RsA] and BusyB = busy[RsB], combinational.
  - Writes to a register with no claim are legal and leave its busy bit 0.
- Requesters must hold Valid, Addr and Data stable until Ready. Data is sampled only in the grant cycle.

Optional Feature:
Macro REGFILE_WB_BYPASS_EN.
- Defined: FwdA = RegWEn && AddrD == RsA && RsA != 0, and FwdDataA = DataD; B is symmetric. This lets the issue stage use a value in the same cycle it is being written, and the consumer may ignore BusyA when FwdA is set.
- Undefined: FwdA and FwdB are tied to 0, FwdDataA and FwdDataB are tied to 0, and no comparators are built.

Decomposition:
- Package regfile_pkg holds:
  - the REG_ZERO address constant
  - the DATA_W and ADDR_W defaults
  - typedef wb_req_t {addr, data}
- Sub-module rr_arb2: a 2-input round-robin arbiter with the LastGnt register, outputs gnt[1:0].
- Scoreboard and output register stay in the top level.

Test Plan:
1. Reset: assert RstN=0 mid-stream with both valid → RegWEn=0, AddrD=0, DataD=0, BusyA=BusyB=0 immediately. After release, Req0 wins the first conflict.
2. Single requester: Req0Valid with Addr=5, Data=0xDEADBEEF at cycle N → Req0Ready=1 in N; RegWEn=1, AddrD=5, DataD=0xDEADBEEF in N+1; RegWEn=0 in N+2.
3. Conflict: both valid and held for 4 cycles (Req0 rd=1, Req1 rd=2) → grants alternate 0,1,0,1; RegWEn stays high for 4 consecutive cycles.
4. Scoreboard: Claim rd=7, then RsA=7 → BusyA=1 until the edge ending the cycle where RegWEn=1 with AddrD=7. Claim 7 again on that same edge → BusyA stays 1.
5. x0: Req1 with Addr=0, Data=0x1234 → Req1Ready=1, RegWEn stays 0. Claim of 0 → BusyA=0 with RsA=0.
6. With REGFILE_WB_BYPASS_EN: RegWEn=1, AddrD=9, DataD=0x55, RsB=9 → FwdB=1, FwdDataB=0x55. Without the macro → FwdB=0.
